exp7_unidade_controle_param: RTL and testbench

EXP7_UNIDADE_CONTROLE_PARAM -- requirements
Module: exp7_unidade_controle_param

---
 rtl/exp7_unidade_controle_param_if.sv | 34 +++
 rtl/exp7_unidade_controle_param.sv | 241 ++++++++++++++++++++++++
 tb/tb_exp7_unidade_controle_param.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exp7_unidade_controle_param_if.sv
// Handshake bundle between the game controller and its datapath/board.
//   master : controller side (drives addresses, strobes, flags, debug state)
//   slave  : datapath/board side (drives jogar, jogada, compare result, modo)
// W is the width of the sequence address and round index.
interface exp7_unidade_controle_param_if #(
    parameter int W = 4
);
    logic         jogar;
    logic         jogada;
    logic         jogada_correta;
    logic         modo;
    logic [W-1:0] endereco;
    logic [W-1:0] rodada;
    logic         registraRC;
    logic         ram_enable;
    logic         mux_leds;
    logic         pronto;
    logic         ganhou;
    logic         perdeu;
    logic         db_timeout;
    logic [3:0]   db_estado;

    modport master (
        input  jogar, jogada, jogada_correta, modo,
        output endereco, rodada, registraRC, ram_enable, mux_leds,
               pronto, ganhou, perdeu, db_timeout, db_estado
    );

    modport slave (
        output jogar, jogada, jogada_correta, modo,
        input  endereco, rodada, registraRC, ram_enable, mux_leds,
               pronto, ganhou, perdeu, db_timeout, db_estado
    );
endinterface

// File: rtl/exp7_unidade_controle_param.sv
// Control unit for a sequence-memory game: shows the stored sequence up to the
// current round, waits for the player to repeat it, and either advances a
// round, appends a new step (modo=1), or ends in win / error / timeout.
//
// Ports:
//   clock  - sole clock, rising edge
//   reset  - asynchronous, active high; returns to IDLE with everything cleared
//   bus    - master modport: jogar/jogada/jogada_correta/modo in;
//            endereco, rodada, registraRC, ram_enable, mux_leds, pronto,
//            ganhou, perdeu, db_timeout, db_estado out
//
// Parameters: N_RODADAS (>=2) rounds to win, MOSTRA_CICLOS (>=1) cycles per
// displayed step, TIMEOUT_CICLOS (>=2) cycles allowed per play.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE    (0)  | waiting for jogar
// PREPARA (1)  | clear address, round and timer
// MOSTRA  (2)  | display sequence steps 0..rodada, MOSTRA_CICLOS each
// ESPERA  (3)  | wait for a play, bounded by TIMEOUT_CICLOS
// REGISTRA(4)  | load the pressed button into the register
// COMPARA (5)  | check the play against memory
// PROX_RODADA(6)| advance round
// NOVA_JOGADA(7)| modo=1: wait for the player's new step
// GRAVA   (8)  | write the new step into memory
// FIM_A   (A)  | won
// FIM_T   (D)  | lost by timeout
// FIM_E   (E)  | lost by wrong play
module exp7_unidade_controle_param #(
    parameter int N_RODADAS      = 16,
    parameter int MOSTRA_CICLOS  = 1000,
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic                              clock,
    input  logic                              reset,
    exp7_unidade_controle_param_if.master     bus
);
    localparam int W    = ($clog2(N_RODADAS) > 1) ? $clog2(N_RODADAS) : 1;
    localparam int TMAX = (MOSTRA_CICLOS > TIMEOUT_CICLOS) ? MOSTRA_CICLOS : TIMEOUT_CICLOS;
    localparam int TW   = ($clog2(TMAX) > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] M_LAST = TW'(MOSTRA_CICLOS - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [W-1:0]  R_LAST = W'(N_RODADAS - 1);
    localparam logic [W-1:0]  W_ONE  = W'(1);

    typedef enum logic [3:0] {
        IDLE        = 4'h0,
        PREPARA     = 4'h1,
        MOSTRA      = 4'h2,
        ESPERA      = 4'h3,
        REGISTRA    = 4'h4,
        COMPARA     = 4'h5,
        PROX_RODADA = 4'h6,
        NOVA_JOGADA = 4'h7,
        GRAVA       = 4'h8,
        FIM_A       = 4'hA,
        FIM_T       = 4'hD,
        FIM_E       = 4'hE
    } state_t;

    typedef struct packed {
        logic registra_rc;
        logic ram_enable;
        logic mux_leds;
        logic pronto;
        logic ganhou;
        logic perdeu;
        logic db_timeout;
    } flags_t;

    state_t          state;
    flags_t          flags;
    logic [W-1:0]    endereco;
    logic [W-1:0]    rodada;
    logic [TW-1:0]   timer;
    logic [3:0]      db_estado;

    // Moore decode, applied to the state being entered so the flags come
    // straight from a register and line up with the state they belong to.
    function automatic flags_t flags_de(input state_t s);
        flags_t f;
        f = '0;
        case (s)
            MOSTRA:   f.mux_leds = 1'b1;
            REGISTRA: f.registra_rc = 1'b1;
            GRAVA: begin
                f.registra_rc = 1'b1;
                f.ram_enable  = 1'b1;
            end
            FIM_A: begin
                f.pronto = 1'b1;
                f.ganhou = 1'b1;
            end
            FIM_E: begin
                f.pronto = 1'b1;
                f.perdeu = 1'b1;
            end
            FIM_T: begin
                f.pronto     = 1'b1;
                f.perdeu     = 1'b1;
                f.db_timeout = 1'b1;
            end
            default: f = '0;
        endcase
        return f;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            flags    <= '0;
            endereco <= '0;
            rodada   <= '0;
            timer    <= '0;
        end else begin
            case (state)
                IDLE, FIM_A, FIM_T, FIM_E: begin
                    if (bus.jogar) begin
                        state    <= PREPARA;
                        flags    <= flags_de(PREPARA);
                        endereco <= '0;
                        rodada   <= '0;
                        timer    <= '0;
                    end
                end
                PREPARA: begin
                    endereco <= '0;
                    rodada   <= '0;
                    timer    <= '0;
                    state    <= MOSTRA;
                    flags    <= flags_de(MOSTRA);
                end
                MOSTRA: begin
                    if (timer == M_LAST) begin
                        timer <= '0;
                        if (endereco == rodada) begin
                            endereco <= '0;
                            state    <= ESPERA;
                            flags    <= flags_de(ESPERA);
                        end else begin
                            endereco <= endereco + W_ONE;
                        end
                    end else begin
                        timer <= timer + T_ONE;
                    end
                end
                ESPERA, NOVA_JOGADA: begin
                    // Timeout is checked first so a play on the last allowed
                    // cycle still counts as too late.
                    if (timer == T_LAST) begin
                        state <= FIM_T;
                        flags <= flags_de(FIM_T);
                    end else if (bus.jogada) begin
                        timer <= '0;
                        if (state == ESPERA) begin
                            state <= REGISTRA;
                            flags <= flags_de(REGISTRA);
                        end else begin
                            state <= GRAVA;
                            flags <= flags_de(GRAVA);
                        end
                    end else begin
                        timer <= timer + T_ONE;
                    end
                end
                REGISTRA: begin
                    state <= COMPARA;
                    flags <= flags_de(COMPARA);
                end
                COMPARA: begin
                    if (!bus.jogada_correta) begin
                        state <= FIM_E;
                        flags <= flags_de(FIM_E);
                    end else if (endereco != rodada) begin
                        endereco <= endereco + W_ONE;
                        timer    <= '0;
                        state    <= ESPERA;
                        flags    <= flags_de(ESPERA);
                    end else if (rodada == R_LAST) begin
                        state <= FIM_A;
                        flags <= flags_de(FIM_A);
                    end else begin
                        state <= PROX_RODADA;
                        flags <= flags_de(PROX_RODADA);
                    end
                end
                PROX_RODADA: begin
                    // Only reachable with rodada < R_LAST, so no wrap.
                    rodada <= rodada + W_ONE;
                    timer  <= '0;
                    if (bus.modo) begin
                        endereco <= rodada + W_ONE;
                        state    <= NOVA_JOGADA;
                        flags    <= flags_de(NOVA_JOGADA);
                    end else begin
                        endereco <= '0;
                        state    <= MOSTRA;
                        flags    <= flags_de(MOSTRA);
                    end
                end
                GRAVA: begin
                    endereco <= '0;
                    timer    <= '0;
                    state    <= MOSTRA;
                    flags    <= flags_de(MOSTRA);
                end
                default: begin
                    state    <= IDLE;
                    flags    <= '0;
                    endereco <= '0;
                    rodada   <= '0;
                    timer    <= '0;
                end
            endcase
        end
    end

    // Any code outside the defined set reads back as F for the one cycle
    // before the FSM lands in IDLE.
    always_comb begin
        db_estado = 4'hF;
        case (state)
            IDLE, PREPARA, MOSTRA, ESPERA, REGISTRA, COMPARA, PROX_RODADA,
            NOVA_JOGADA, GRAVA, FIM_A, FIM_T, FIM_E: db_estado = state;
            default: db_estado = 4'hF;
        endcase
    end

    assign bus.endereco   = endereco;
    assign bus.rodada     = rodada;
    assign bus.registraRC = flags.registra_rc;
    assign bus.ram_enable = flags.ram_enable;
    assign bus.mux_leds   = flags.mux_leds;
    assign bus.pronto     = flags.pronto;
    assign bus.ganhou     = flags.ganhou;
    assign bus.perdeu     = flags.perdeu;
    assign bus.db_timeout = flags.db_timeout;
    assign bus.db_estado  = db_estado;
endmodule

// File: tb/tb_exp7_unidade_controle_param.sv
module tb_exp7_unidade_controle_param;
    localparam int N = 4;
    localparam int M = 4;
    localparam int T = 20;
    localparam int W = 2;

    // flag order: registraRC, ram_enable, mux_leds, pronto, ganhou, perdeu, db_timeout
    localparam logic [6:0] F_NONE   = 7'b0000000;
    localparam logic [6:0] F_MOSTRA = 7'b0010000;
    localparam logic [6:0] F_REG    = 7'b1000000;
    localparam logic [6:0] F_GRAVA  = 7'b1100000;
    localparam logic [6:0] F_A      = 7'b0001100;
    localparam logic [6:0] F_E      = 7'b0001010;
    localparam logic [6:0] F_T      = 7'b0001011;

    logic clock;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   reg_cnt = 0;
    int   ram_cnt = 0;

    exp7_unidade_controle_param_if #(.W(W)) bus ();

    exp7_unidade_controle_param #(
        .N_RODADAS(N), .MOSTRA_CICLOS(M), .TIMEOUT_CICLOS(T)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [14:0] obs();
        return {bus.db_estado, bus.endereco, bus.rodada, bus.registraRC, bus.ram_enable,
                bus.mux_leds, bus.pronto, bus.ganhou, bus.perdeu, bus.db_timeout};
    endfunction

    function automatic logic [14:0] ev(input logic [3:0] s, input int e, input int r,
                                       input logic [6:0] f);
        logic [W-1:0] ee;
        logic [W-1:0] rr;
        ee = W'(e);
        rr = W'(r);
        return {s, ee, rr, f};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
        if (bus.registraRC) reg_cnt++;
        if (bus.ram_enable) ram_cnt++;
    endtask

    task automatic do_reset();
        bus.jogar = 1'b0;
        bus.jogada = 1'b0;
        bus.jogada_correta = 1'b1;
        bus.modo = 1'b0;
        #2 reset = 1'b1;
        @(posedge clock);
        #2 reset = 1'b0;
    endtask

    // Game-level model: round r shows r+1 steps of M cycles, then expects
    // r+1 plays each within T cycles; a play costs REGISTRA+COMPARA; the last
    // correct play of a non-final round advances the round (modo=1 adds a
    // NOVA_JOGADA/GRAVA pair that writes one new step).
    // bad_kind: 0 win, 1 wrong play, 2 timeout, 3 timeout with late jogada,
    // 4 reset during ESPERA.
    task automatic play_game(input bit m, input int bad_round, input int bad_idx,
                             input int bad_kind);
        int exp_reg;
        int exp_ram;
        int d;
        bit done;
        bit wrong;
        logic [14:0] got;
        logic [14:0] want;
        exp_reg = 0;
        exp_ram = 0;
        done = 1'b0;
        reg_cnt = 0;
        ram_cnt = 0;
        bus.modo = m;
        bus.jogada = 1'b0;
        bus.jogada_correta = 1'b1;
        bus.jogar = 1'b1;
        step();
        bus.jogar = 1'b0;
        got = obs();
        tests++;
        if ({got[14:11], got[6:0]} !== {4'h1, F_NONE}) begin
            fails++;
            $display("FAIL prepara: got %h want state 1 no flags", got);
        end
        for (int r = 0; r < N && !done; r++) begin
            for (int i = 0; i < (r + 1) * M; i++) begin
                bus.jogar = 1'($urandom_range(0, 1));
                step();
                got = obs();
                want = ev(4'h2, i / M, r, F_MOSTRA);
                tests++;
                if (got !== want) begin
                    fails++;
                    $display("FAIL mostra r=%0d i=%0d: got %h want %h", r, i, got, want);
                end
            end
            bus.jogar = 1'($urandom_range(0, 1));
            step();
            got = obs();
            want = ev(4'h3, 0, r, F_NONE);
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL espera_entry r=%0d: got %h want %h", r, got, want);
            end
            for (int k = 0; k <= r && !done; k++) begin
                if (r == bad_round && k == bad_idx && bad_kind == 4) begin
                    repeat ($urandom_range(1, 5)) begin
                        bus.jogar = 1'($urandom_range(0, 1));
                        step();
                    end
                    bus.jogar = 1'b0;
                    #2 reset = 1'b1;
                    #1;
                    got = obs();
                    tests++;
                    if (got !== 15'h0) begin
                        fails++;
                        $display("FAIL reset_espera: got %h want 0", got);
                    end
                    @(posedge clock);
                    #2 reset = 1'b0;
                    repeat (3) begin
                        step();
                        got = obs();
                        tests++;
                        if (got !== 15'h0) begin
                            fails++;
                            $display("FAIL idle_after_reset: got %h want 0", got);
                        end
                    end
                    done = 1'b1;
                end else if (r == bad_round && k == bad_idx && bad_kind >= 2) begin
                    repeat (T - 1) begin
                        bus.jogar = 1'($urandom_range(0, 1));
                        step();
                        got = obs();
                        want = ev(4'h3, k, r, F_NONE);
                        tests++;
                        if (got !== want) begin
                            fails++;
                            $display("FAIL espera_wait r=%0d k=%0d: got %h want %h", r, k, got, want);
                        end
                    end
                    bus.jogar = 1'b0;
                    bus.jogada = (bad_kind == 3);
                    step();
                    bus.jogada = 1'b0;
                    got = obs();
                    want = ev(4'hD, k, r, F_T);
                    tests++;
                    if (got !== want) begin
                        fails++;
                        $display("FAIL timeout late=%0d: got %h want %h", bad_kind == 3, got, want);
                    end
                    done = 1'b1;
                end else begin
                    d = $urandom_range(0, T - 2);
                    repeat (d) begin
                        bus.jogar = 1'($urandom_range(0, 1));
                        step();
                        got = obs();
                        want = ev(4'h3, k, r, F_NONE);
                        tests++;
                        if (got !== want) begin
                            fails++;
                            $display("FAIL espera_idle r=%0d k=%0d: got %h want %h", r, k, got, want);
                        end
                    end
                    bus.jogar = 1'b0;
                    bus.jogada = 1'b1;
                    step();
                    bus.jogada = 1'b0;
                    exp_reg++;
                    got = obs();
                    want = ev(4'h4, k, r, F_REG);
                    tests++;
                    if (got !== want) begin
                        fails++;
                        $display("FAIL registra r=%0d k=%0d: got %h want %h", r, k, got, want);
                    end
                    wrong = (bad_kind == 1 && r == bad_round && k == bad_idx);
                    bus.jogada_correta = !wrong;
                    step();
                    got = obs();
                    want = ev(4'h5, k, r, F_NONE);
                    tests++;
                    if (got !== want) begin
                        fails++;
                        $display("FAIL compara r=%0d k=%0d: got %h want %h", r, k, got, want);
                    end
                    step();
                    bus.jogada_correta = 1'b1;
                    if (wrong) begin
                        want = ev(4'hE, k, r, F_E);
                        done = 1'b1;
                    end else if (k < r) begin
                        want = ev(4'h3, k + 1, r, F_NONE);
                    end else if (r == N - 1) begin
                        want = ev(4'hA, k, r, F_A);
                        done = 1'b1;
                    end else begin
                        want = ev(4'h6, k, r, F_NONE);
                    end
                    got = obs();
                    tests++;
                    if (got !== want) begin
                        fails++;
                        $display("FAIL after_compara r=%0d k=%0d: got %h want %h", r, k, got, want);
                    end
                    if (!done && k == r && m) begin
                        step();
                        d = $urandom_range(0, T - 2);
                        for (int j = 0; j <= d; j++) begin
                            if (j > 0) step();
                            got = obs();
                            want = ev(4'h7, r + 1, r + 1, F_NONE);
                            tests++;
                            if (got !== want) begin
                                fails++;
                                $display("FAIL nova_jogada r=%0d j=%0d: got %h want %h", r, j, got, want);
                            end
                        end
                        bus.jogada = 1'b1;
                        step();
                        bus.jogada = 1'b0;
                        exp_reg++;
                        exp_ram++;
                        got = obs();
                        want = ev(4'h8, r + 1, r + 1, F_GRAVA);
                        tests++;
                        if (got !== want) begin
                            fails++;
                            $display("FAIL grava r=%0d: got %h want %h", r, got, want);
                        end
                    end
                end
            end
        end
        tests++;
        if (reg_cnt !== exp_reg) begin
            fails++;
            $display("FAIL registra_count: got %0d want %0d", reg_cnt, exp_reg);
        end
        tests++;
        if (ram_cnt !== exp_ram) begin
            fails++;
            $display("FAIL ram_enable_count: got %0d want %0d", ram_cnt, exp_ram);
        end
    endtask

    task automatic test_reset();
        logic [14:0] got;
        reset = 1'b1;
        bus.jogar = 1'b0;
        bus.jogada = 1'b0;
        bus.jogada_correta = 1'b1;
        bus.modo = 1'b0;
        #3;
        got = obs();
        tests++;
        if (got !== 15'h0) begin
            fails++;
            $display("FAIL reset_state: got %h want 0", got);
        end
        @(posedge clock);
        #2 reset = 1'b0;
        repeat (4) begin
            bus.jogada = 1'($urandom_range(0, 1));
            step();
            got = obs();
            tests++;
            if (got !== 15'h0) begin
                fails++;
                $display("FAIL idle_hold: got %h want 0", got);
            end
        end
        bus.jogada = 1'b0;
        do_reset();
    endtask

    task automatic test_win_modo0();
        play_game(1'b0, -1, -1, 0);
        tests++;
        if (reg_cnt !== N * (N + 1) / 2) begin
            fails++;
            $display("FAIL win_registra_total: got %0d want %0d", reg_cnt, N * (N + 1) / 2);
        end
        do_reset();
    endtask

    task automatic test_wrong_play();
        logic [14:0] got;
        play_game(1'b0, 1, 0, 1);
        repeat (2) begin
            step();
            got = obs();
            tests++;
            if (got !== ev(4'hE, 0, 1, F_E)) begin
                fails++;
                $display("FAIL fim_e_hold: got %h want %h", got, ev(4'hE, 0, 1, F_E));
            end
        end
        bus.jogar = 1'b1;
        step();
        bus.jogar = 1'b0;
        got = obs();
        tests++;
        if ({got[14:11], got[6:0]} !== {4'h1, F_NONE}) begin
            fails++;
            $display("FAIL restart_prepara: got %h want state 1 no flags", got);
        end
        step();
        got = obs();
        tests++;
        if (got !== ev(4'h2, 0, 0, F_MOSTRA)) begin
            fails++;
            $display("FAIL restart_mostra: got %h want %h", got, ev(4'h2, 0, 0, F_MOSTRA));
        end
        do_reset();
    endtask

    task automatic test_timeout();
        play_game(1'b0, 0, 0, 2);
        do_reset();
        play_game(1'b0, 2, 1, 3);
        do_reset();
    endtask

    task automatic test_modo1();
        play_game(1'b1, -1, -1, 0);
        do_reset();
        play_game(1'b1, 2, 2, 1);
        do_reset();
    endtask

    task automatic test_reset_mid();
        logic [14:0] got;
        play_game(1'b0, 2, 0, 4);
        do_reset();
        bus.jogar = 1'b1;
        step();
        bus.jogar = 1'b0;
        repeat ($urandom_range(1, M)) step();
        #2 reset = 1'b1;
        #1;
        got = obs();
        tests++;
        if (got !== 15'h0) begin
            fails++;
            $display("FAIL reset_mostra: got %h want 0", got);
        end
        @(posedge clock);
        #2 reset = 1'b0;
    endtask

    task automatic test_random_games();
        int r;
        int k;
        int kind;
        repeat (8) begin
            r = $urandom_range(0, N - 1);
            k = $urandom_range(0, r);
            kind = $urandom_range(0, 4);
            play_game(1'($urandom_range(0, 1)), r, k, kind);
            do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_win_modo0();
        test_wrong_play();
        test_timeout();
        test_modo1();
        test_reset_mid();
        test_random_games();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
